// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: measures VGA line length and frame height on the pclk
// domain, flags sticky timing errors against the programmed totals, and
// optionally signs each frame's pixel data with CRC-16-CCITT.
// Optional feature macro: VGA_MON_CRC_EN (builds the CRC datapath; when it is
// undefined, crc is tied to 16'h0000 and crc_valid to 0).
// rst is asynchronous and active-low despite its name.
module vga_frame_monitor #(
  parameter int COLOR_W  = 4,
  parameter int H_TOTAL  = 1056,
  parameter int V_TOTAL  = 628,
  parameter int FRAMES   = 2,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               hs,
  input  logic               vs,
  input  logic [COLOR_W-1:0] r,
  input  logic [COLOR_W-1:0] g,
  input  logic [COLOR_W-1:0] b,
  input  logic               arm,
  output logic [15:0]        line_len,
  output logic [15:0]        frame_lines,
  output logic [7:0]         frame_cnt,
  output logic               h_err,
  output logic               v_err,
  output logic               done,
  output logic [15:0]        crc,
  output logic               crc_valid
);

  localparam int          PIX_W = 3 * COLOR_W;
  localparam logic [15:0] H_EXP = 16'(H_TOTAL);
  localparam logic [15:0] V_EXP = 16'(V_TOTAL);
  localparam logic [7:0]  F_EXP = 8'(FRAMES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        hs_q, vs_q;
  logic        hs_edge, vs_edge;
  logic [15:0] hcnt, vcnt;
  logic [15:0] line_meas, lines_meas;
  logic        first_line;
  logic        frame_end, last_frame;

  // "Asserted" means the level equals SYNC_POL; a leading edge is asserted
  // now and not asserted in the registered copy.
  assign hs_edge    = (hs == SYNC_POL) && (hs_q != SYNC_POL);
  assign vs_edge    = (vs == SYNC_POL) && (vs_q != SYNC_POL);

  // An hs edge in the same cycle as a vs edge closes the ending frame.
  assign line_meas  = hcnt + 16'd1;
  assign lines_meas = vcnt + {15'd0, hs_edge};

  // arm outranks a coincident vs edge, so a frame only closes without it.
  assign frame_end  = (state == RUN) && vs_edge && !arm;
  assign last_frame = frame_end && ((frame_cnt + 8'd1) == F_EXP);

  // Sync inputs registered once for leading-edge detection.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      hs_q <= 1'b0;
      vs_q <= 1'b0;
    end else begin
      hs_q <= hs;
      vs_q <= vs;
    end
  end

  // Free-running line/frame counters; hcnt saturates so a lost hsync is visible.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      hcnt <= 16'd0;
      vcnt <= 16'd0;
    end else begin
      if (hs_edge)
        hcnt <= 16'd0;
      else if (hcnt != 16'hFFFF)
        hcnt <= hcnt + 16'd1;

      if (vs_edge)
        vcnt <= 16'd0;
      else if (hs_edge)
        vcnt <= vcnt + 16'd1;
    end
  end

  // State register.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic: arm forces IDLE from any state.
  always_comb begin
    state_nxt = state;
    if (arm) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (vs_edge) state_nxt = RUN;
        RUN:     if (last_frame) state_nxt = DONE;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Measurement outputs follow every edge except while frozen in DONE or on arm.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      line_len    <= 16'd0;
      frame_lines <= 16'd0;
    end else if (!arm && (state != DONE)) begin
      if (hs_edge) line_len    <= line_meas;
      if (vs_edge) frame_lines <= lines_meas;
    end
  end

  // Frame count, sticky error flags and done; the first line in RUN is partial
  // and is therefore never checked.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      frame_cnt  <= 8'd0;
      h_err      <= 1'b0;
      v_err      <= 1'b0;
      done       <= 1'b0;
      first_line <= 1'b0;
    end else if (arm) begin
      frame_cnt  <= 8'd0;
      h_err      <= 1'b0;
      v_err      <= 1'b0;
      done       <= 1'b0;
      first_line <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (vs_edge) first_line <= 1'b1;
        end
        RUN: begin
          if (hs_edge) begin
            if (first_line)
              first_line <= 1'b0;
            else if (line_meas != H_EXP)
              h_err <= 1'b1;
          end else if (hcnt == 16'hFFFF) begin
            h_err <= 1'b1;
          end
          if (vs_edge) begin
            frame_cnt <= frame_cnt + 8'd1;
            if (lines_meas != V_EXP) v_err <= 1'b1;
            if (last_frame) done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef VGA_MON_CRC_EN
  logic [PIX_W-1:0] pix;
  logic [15:0]      crc_run;

  // CRC-16-CCITT (poly 0x1021), MSB first, whole pixel word folded per cycle.
  function automatic logic [15:0] crc_next(input logic [15:0] c_in,
                                           input logic [PIX_W-1:0] d);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = PIX_W - 1; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  assign pix = {r, g, b};

  // Running signature; the vs-edge pixel is the first word of the new frame.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst)
      crc_run <= 16'hFFFF;
    else if (vs_edge)
      crc_run <= crc_next(16'hFFFF, pix);
    else
      crc_run <= crc_next(crc_run, pix);
  end

  // Publish the finished frame's signature only for frames closed in RUN.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      crc       <= 16'h0000;
      crc_valid <= 1'b0;
    end else begin
      crc_valid <= 1'b0;
      if (frame_end) begin
        crc       <= crc_run;
        crc_valid <= 1'b1;
      end
    end
  end
`else
  logic unused_pix;

  assign unused_pix = ^{r, g, b};
  assign crc        = 16'h0000;
  assign crc_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench for vga_frame_monitor using a small 16x8 timing (FRAMES=2)
// so whole frames stay short. CRC expectations follow VGA_MON_CRC_EN.
module tb_vga_frame_monitor;

  localparam int H = 16;
  localparam int V = 8;
`ifdef VGA_MON_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        rst;
  logic        hs_i, vs_i, arm_i;
  logic [3:0]  r_i, g_i, b_i;
  logic [15:0] line_len, frame_lines, crc;
  logic [7:0]  frame_cnt;
  logic        h_err, v_err, done, crc_valid;

  int          n_cmp   = 0;
  int          n_err   = 0;
  int          n_pulse = 0;
  logic [15:0] m_run   = 16'hFFFF;
  logic [15:0] m_frame = 16'hFFFF;
  logic [15:0] crc_hold, crc_a;

  vga_frame_monitor #(
    .COLOR_W(4), .H_TOTAL(H), .V_TOTAL(V), .FRAMES(2), .SYNC_POL(1'b1)
  ) dut (
    .pclk(pclk), .rst(rst), .hs(hs_i), .vs(vs_i),
    .r(r_i), .g(g_i), .b(b_i), .arm(arm_i),
    .line_len(line_len), .frame_lines(frame_lines), .frame_cnt(frame_cnt),
    .h_err(h_err), .v_err(v_err), .done(done),
    .crc(crc), .crc_valid(crc_valid)
  );

  always #5 pclk = ~pclk;

  // Count crc_valid pulses, sampled mid-cycle.
  always @(negedge pclk) if (crc_valid === 1'b1) n_pulse++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference CRC: XOR the data bit into the top of the register, then divide.
  function automatic logic [15:0] m_crc(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] x;
    x = c;
    for (int i = 11; i >= 0; i--) begin
      x = x ^ {d[i], 15'd0};
      if (x[15]) x = (x << 1) ^ 16'h1021;
      else       x = x << 1;
    end
    return x;
  endfunction

  function automatic logic [15:0] exp_crc(input logic [15:0] v);
    return CRC_ON ? v : 16'h0000;
  endfunction

  // One pixel clock: drive on the falling edge, return just after the rising edge.
  task automatic cyc(input logic h, input logic v, input logic [3:0] rv, input logic a);
    logic [11:0] pix;
    @(negedge pclk);
    hs_i = h; vs_i = v; r_i = rv; arm_i = a;
    pix = {rv, 8'h00};
    if (v) begin
      m_frame = m_run;
      m_run   = m_crc(16'hFFFF, pix);
    end else begin
      m_run = m_crc(m_run, pix);
    end
    @(posedge pclk);
    #1;
  endtask

  task automatic vs_edge();
    cyc(1'b1, 1'b1, 4'h0, 1'b0);
  endtask

  task automatic do_arm();
    cyc(1'b0, 1'b0, 4'h0, 1'b1);
  endtask

  // Rest of a frame after its vs-edge cycle: line 0 from cycle 1, then full lines.
  task automatic frame(input int lines, input bit short_last, input bit flip);
    int len;
    for (int l = 0; l < lines; l++) begin
      len = (short_last && l == lines - 1) ? H - 1 : H;
      for (int c = (l == 0) ? 1 : 0; c < len; c++)
        cyc(c < 2, 1'b0, (flip && l == 2 && c == 5) ? 4'hF : 4'h0, 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; hs_i = 1'b0; vs_i = 1'b0; arm_i = 1'b0;
    r_i = 4'h0; g_i = 4'h0; b_i = 4'h0;
    repeat (3) @(posedge pclk);
    #1;
    check("rst_line_len", line_len, 0);
    check("rst_frame_lines", frame_lines, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_h_err", h_err, 0);
    check("rst_v_err", v_err, 0);
    check("rst_done", done, 0);
    check("rst_crc", crc, 0);
    check("rst_crc_valid", crc_valid, 0);
    @(negedge pclk);
    rst = 1'b1;

    // Ideal timing, black pixels.
    vs_edge();
    check("s1_enter_cnt", frame_cnt, 0);
    check("s1_enter_cv", crc_valid, 0);
    frame(V, 1'b0, 1'b0);
    vs_edge();
    check("s1_f1_cnt", frame_cnt, 1);
    check("s1_f1_lines", frame_lines, V);
    check("s1_f1_len", line_len, H);
    check("s1_f1_cv", crc_valid, CRC_ON);
    check("s1_f1_crc", crc, exp_crc(m_frame));
    check("s1_f1_done", done, 0);
    crc_a = crc;
    frame(V, 1'b0, 1'b0);
    vs_edge();
    check("s1_f2_cnt", frame_cnt, 2);
    check("s1_f2_done", done, 1);
    check("s1_f2_herr", h_err, 0);
    check("s1_f2_verr", v_err, 0);
    check("s1_f2_cv", crc_valid, CRC_ON);
    check("s1_f2_crc", crc, exp_crc(m_frame));
    check("s1_crc_equal", crc == crc_a, 1);
    crc_hold = exp_crc(m_frame);

    // DONE freezes outputs even across a bad frame.
    frame(V, 1'b1, 1'b1);
    vs_edge();
    check("done_len_frozen", line_len, H);
    check("done_herr_frozen", h_err, 0);
    check("done_cnt_frozen", frame_cnt, 2);
    check("done_cv_quiet", crc_valid, 0);
    check("done_crc_frozen", crc, crc_hold);

    // arm in DONE clears control, holds measurements.
    do_arm();
    check("arm_done", done, 0);
    check("arm_cnt", frame_cnt, 0);
    check("arm_len_held", line_len, H);
    check("arm_crc_held", crc, crc_hold);

    // Short line at the end of the first counted frame.
    vs_edge();
    frame(V, 1'b1, 1'b0);
    vs_edge();
    check("short_len", line_len, H - 1);
    check("short_herr", h_err, 1);
    check("short_verr", v_err, 0);
    check("short_lines", frame_lines, V);
    frame(V, 1'b0, 1'b0);
    vs_edge();
    check("short_herr_sticky", h_err, 1);
    check("short_done", done, 1);
    check("short_len_good", line_len, H);
    do_arm();
    check("arm_clr_herr", h_err, 0);

    // Short frame followed by a good one.
    vs_edge();
    frame(V - 1, 1'b0, 1'b0);
    vs_edge();
    check("vshort_lines", frame_lines, V - 1);
    check("vshort_verr", v_err, 1);
    check("vshort_herr", h_err, 0);
    frame(V, 1'b0, 1'b0);
    vs_edge();
    check("vshort_good_lines", frame_lines, V);
    check("vshort_verr_sticky", v_err, 1);
    check("vshort_done", done, 1);
    do_arm();
    check("arm_clr_verr", v_err, 0);

    // One flipped pixel changes the signature.
    vs_edge();
    frame(V, 1'b0, 1'b0);
    vs_edge();
    check("flip_ref_crc", crc, exp_crc(m_frame));
    crc_a = crc;
    frame(V, 1'b0, 1'b1);
    vs_edge();
    check("flip_crc", crc, exp_crc(m_frame));
    check("flip_crc_differs", crc != crc_a, CRC_ON);
    do_arm();

    // arm coincident with a vs edge wins.
    vs_edge();
    frame(V, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 4'h0, 1'b1);
    check("armvs_cnt", frame_cnt, 0);
    check("armvs_cv", crc_valid, 0);
    check("armvs_done", done, 0);
    frame(V, 1'b0, 1'b0);
    vs_edge();
    check("armvs_idle_cnt", frame_cnt, 0);
    check("armvs_idle_cv", crc_valid, 0);

    // Asynchronous reset mid-line during RUN.
    frame(3, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 4'h0, 1'b0);
    @(negedge pclk);
    #1 rst = 1'b0;
    #1;
    check("arst_len", line_len, 0);
    check("arst_lines", frame_lines, 0);
    check("arst_crc", crc, 0);
    @(posedge pclk);
    @(negedge pclk);
    rst = 1'b1;
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 4'h0, 1'b0);
    frame(V, 1'b0, 1'b0);
    check("arst_wait_cnt", frame_cnt, 0);
    check("arst_wait_herr", h_err, 0);
    vs_edge();
    frame(V, 1'b0, 1'b0);
    vs_edge();
    check("arst_f1_cnt", frame_cnt, 1);
    check("arst_f1_herr", h_err, 0);
    check("arst_f1_verr", v_err, 0);
    check("arst_f1_crc", crc, exp_crc(m_frame));
    cyc(1'b0, 1'b0, 4'h0, 1'b0);
    check("arst_cv_drop", crc_valid, 0);

    @(negedge pclk);
    check("crc_valid_pulses", n_pulse, CRC_ON ? 9 : 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
